// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage MIPS core.
// Merges per-stage stall requests into the stall vector (PC, IF, ID, EX,
// MEM, WB = bits 0..5), turns MEM-stage exceptions / ERET into a flush plus
// PC redirect, defers the redirect while an instruction fetch is still
// outstanding, and counts stalled cycles for performance analysis.
//
// Handshake note: there is no valid/ready pair here. A stall bit set means
// "hold this register on the coming edge"; flush_o and redirect_o act on the
// same edge they are observed, so every output is combinational (Mealy).
module pipe_ctrl #(
    parameter logic [31:0] INT_VECTOR = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000e
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pend_pc;
    logic [31:0] stall_cnt;
    logic [31:0] target;
    logic        pend_load;

    // Redirect target for the exception currently presented by MEM.
    always_comb begin
        target = EXC_VECTOR;
        if (excepttype_i == 32'h0000_0001) begin
            target = INT_VECTOR;
        end else if (excepttype_i == ERET_CODE) begin
            target = cp0_epc_i;
        end
    end

    // Next-state and Mealy outputs; everything is held at 0 while in reset.
    always_comb begin
        next_state = state;
        stall_o    = 6'b000000;
        flush_o    = 1'b0;
        redirect_o = 1'b0;
        new_pc_o   = 32'h0;
        pend_load  = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (excepttype_i != 32'h0) begin
                        flush_o = 1'b1;
                        if (stallreq_if_i) begin
                            // Fetch still on the bus: hold PC/IF and remember the target.
                            stall_o    = 6'b000011;
                            pend_load  = 1'b1;
                            next_state = PEND;
                        end else begin
                            redirect_o = 1'b1;
                            new_pc_o   = target;
                        end
                    end else if (stallreq_mem_i) begin
                        stall_o = 6'b011111;
                    end else if (stallreq_ex_i) begin
                        stall_o = 6'b001111;
                    end else if (stallreq_id_i) begin
                        stall_o = 6'b000111;
                    end else if (stallreq_if_i) begin
                        stall_o = 6'b000011;
                    end
                end
                PEND: begin
                    // Pipeline is already flushed; only the fetch bus matters.
                    if (stallreq_if_i) begin
                        stall_o = 6'b000011;
                    end else begin
                        redirect_o = 1'b1;
                        new_pc_o   = pend_pc;
                        flush_o    = 1'b1;
                        next_state = RUN;
                    end
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    // State, pending target and stall-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pend_pc   <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            state <= next_state;
            if (pend_load) begin
                pend_pc <= target;
            end
            if (stall_o[0]) begin
                stall_cnt <= stall_cnt + 32'h1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl. Inputs change on the falling
// edge; combinational outputs and the counter are checked 1 time unit later.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] new_pc_o;
    logic [31:0] stall_cnt_o;

    int vectors;
    int miscompares;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if_i  (stallreq_if_i),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .excepttype_i   (excepttype_i),
        .cp0_epc_i      (cp0_epc_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .redirect_o     (redirect_o),
        .new_pc_o       (new_pc_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check all four Mealy outputs at once.
    task automatic chk_out(input string tag, input logic [5:0] st, input logic fl,
                           input logic rd, input logic [31:0] pc);
        chk({tag, ".stall"}, {26'h0, stall_o}, {26'h0, st});
        chk({tag, ".flush"}, {31'h0, flush_o}, {31'h0, fl});
        chk({tag, ".redir"}, {31'h0, redirect_o}, {31'h0, rd});
        chk({tag, ".newpc"}, new_pc_o, pc);
    endtask

    task automatic drive(input logic r, input logic i_f, input logic i_d, input logic i_e,
                         input logic i_m, input logic [31:0] exc, input logic [31:0] epc);
        @(negedge clk);
        rst            = r;
        stallreq_if_i  = i_f;
        stallreq_id_i  = i_d;
        stallreq_ex_i  = i_e;
        stallreq_mem_i = i_m;
        excepttype_i   = exc;
        cp0_epc_i      = epc;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; stallreq_if_i = 1'b1; stallreq_id_i = 1'b1;
        stallreq_ex_i = 1'b1; stallreq_mem_i = 1'b1;
        excepttype_i = 32'h0; cp0_epc_i = 32'h0;

        // Reset held two edges with every request high.
        @(posedge clk);
        @(posedge clk);
        drive(1, 1, 1, 1, 1, 32'h8, 32'h0);
        chk_out("rst", 6'b000000, 0, 0, 32'h0);
        chk("rst.cnt", stall_cnt_o, 32'h0);

        // Release: MEM request has top priority. Counter 0 -> 1.
        drive(0, 1, 1, 1, 1, 32'h0, 32'h0);
        chk_out("rel", 6'b011111, 0, 0, 32'h0);
        chk("rel.cnt", stall_cnt_o, 32'h0);

        // ID + EX for three cycles. Counter 1 -> 4.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 0, 32'h0, 32'h0);
            chk_out("idex", 6'b001111, 0, 0, 32'h0);
        end
        drive(0, 0, 1, 0, 0, 32'h0, 32'h0);
        chk("idex.cnt", stall_cnt_o, 32'd4);
        chk_out("id", 6'b000111, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        chk_out("if", 6'b000011, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_out("none", 6'b000000, 0, 0, 32'h0);
        chk("none.cnt", stall_cnt_o, 32'd6);

        // Exceptions in RUN override MEM stall; back-to-back each honoured.
        drive(0, 0, 0, 0, 1, 32'h8, 32'h0);
        chk_out("exc8", 6'b000000, 1, 1, 32'h40);
        drive(0, 0, 1, 1, 1, 32'h1, 32'h0);
        chk_out("int", 6'b000000, 1, 1, 32'h20);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_out("idle", 6'b000000, 0, 0, 32'h0);
        chk("idle.cnt", stall_cnt_o, 32'd6);

        // ERET with a fetch outstanding: deferred redirect. Counter 6 -> 9.
        drive(0, 1, 0, 0, 0, 32'he, 32'hBFC0_0100);
        chk_out("eret0", 6'b000011, 1, 0, 32'h0);
        drive(0, 1, 0, 0, 1, 32'h0, 32'h0);
        chk_out("eret1", 6'b000011, 0, 0, 32'h0);
        drive(0, 1, 1, 1, 1, 32'h8, 32'h0);
        chk_out("eret2", 6'b000011, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_out("eret3", 6'b000000, 1, 1, 32'hBFC0_0100);
        chk("eret3.cnt", stall_cnt_o, 32'd9);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_out("eret4", 6'b000000, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h8, 32'h0);
        chk_out("eret5", 6'b000000, 1, 1, 32'h40);

        // Reset during PEND abandons the pending redirect.
        drive(0, 1, 0, 0, 0, 32'h1, 32'h0);
        chk_out("rp0", 6'b000011, 1, 0, 32'h0);
        drive(1, 1, 0, 0, 0, 32'h0, 32'h0);
        chk_out("rp1", 6'b000000, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk_out("rp2", 6'b000000, 0, 0, 32'h0);
        chk("rp2.cnt", stall_cnt_o, 32'h0);

        // New excepttype while in PEND is ignored; original target kept.
        drive(0, 1, 0, 0, 0, 32'h8, 32'h0);
        chk_out("pi0", 6'b000011, 1, 0, 32'h0);
        drive(0, 1, 0, 0, 0, 32'h1, 32'h0);
        chk_out("pi1", 6'b000011, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h1, 32'h0);
        chk_out("pi2", 6'b000000, 1, 1, 32'h40);
        chk("pi2.cnt", stall_cnt_o, 32'd2);

        // Counter wrap via deposit.
        drive(0, 1, 0, 0, 0, 32'h0, 32'h0);
        dut.stall_cnt = 32'hFFFF_FFFF;
        #1;
        chk("wrap.pre", stall_cnt_o, 32'hFFFF_FFFF);
        chk_out("wrap.st", 6'b000011, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("wrap.cnt", stall_cnt_o, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("wrap.hold", stall_cnt_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
